// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: FSM state encoding
// and default geometry.
package regfile_pkg;

    // Default register width and address width (8 registers of 8 bits)
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    // Sequencer state encoding
    typedef logic [0:0] state_t;
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

endpackage

// File: rtl/regfile_mp_if.sv
// Decoder <-> register file bus: read/write addresses and strobes from the
// decoder (master), operand data, read-valid and busy back from the file (slave).
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [ADDR_W-1:0] aa;
    logic [ADDR_W-1:0] ba;
    logic              re;
    logic [ADDR_W-1:0] da;
    logic [DATA_W-1:0] data_in;
    logic              wr;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              rd_valid;
    logic              busy;

    modport master (
        output aa, ba, re, da, data_in, wr,
        input  data_a, data_b, rd_valid, busy
    );

    modport slave (
        input  aa, ba, re, da, data_in, wr,
        output data_a, data_b, rd_valid, busy
    );
endinterface

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks clr_ptr over every register, one per
// cycle, then hands the file over to normal operation.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic [0:0]        o_state,
    output logic              o_busy
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic              r_busy;

    // State, sweep pointer and busy flag; reset restarts the sweep from 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
            r_busy    <= 1'b1;
        end else if (r_state == CLEAR) begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
            if (r_clr_ptr == LAST_ADDR) begin
                r_state <= RUN;
                r_busy  <= 1'b0;
            end
        end
    end

    // Clear writes are suppressed while reset is held so the pointer stays parked
    assign o_clr_we   = (r_state == CLEAR) && !rst;
    assign o_clr_addr = r_clr_ptr;
    assign o_state    = r_state;
    assign o_busy     = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Register file: one write port, two registered read ports, optional
// hardwired-zero register 0. Storage is cleared by a sweep after reset.
// Optional feature macro: REGFILE_BYPASS_EN forwards same-cycle write data
// to a read port addressing the register being written; without it reads
// return the pre-write contents.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input logic          clk,
    input logic          rst,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [0:0]        w_state;
    logic              w_busy;
    logic              w_run;
    logic              w_user_we;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [ADDR_W-1:0] w_raddr [2];
    logic              r_rd_valid;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_state    (w_state),
        .o_busy     (w_busy)
    );

    assign w_run = (w_state == RUN);

    // User writes only in RUN, never alongside reset, never into a hardwired R0
    assign w_user_we = w_run && bus.wr && !rst &&
                       !((ZERO_REG != 0) && (bus.da == '0));

    // Single physical write port shared by the clear sweep and the user
    assign w_we    = w_clr_we | w_user_we;
    assign w_waddr = w_clr_we ? w_clr_addr : bus.da;
    assign w_wdata = w_clr_we ? '0 : bus.data_in;

    // Storage array write
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign w_raddr[0] = bus.aa;
    assign w_raddr[1] = bus.ba;

    // One identical registered read path per port
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
        logic              w_is_zero;
        logic [DATA_W-1:0] w_rd_word;
        logic [DATA_W-1:0] r_rdata;

        assign w_is_zero = (ZERO_REG != 0) && (w_raddr[gi] == '0);

`ifdef REGFILE_BYPASS_EN
        // w_user_we already excludes R0, so a hardwired zero is never forwarded
        assign w_rd_word = w_is_zero ? '0 :
                           (w_user_we && (bus.da == w_raddr[gi])) ? bus.data_in :
                           r_mem[w_raddr[gi]];
`else
        assign w_rd_word = w_is_zero ? '0 : r_mem[w_raddr[gi]];
`endif

        // Output register: zero through reset and sweep, load on re, else hold
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rdata <= '0;
            end else if (!w_run) begin
                r_rdata <= '0;
            end else if (bus.re) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    // Read-valid pulses for one cycle after each accepted read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_run && bus.re;
        end
    end

    assign bus.data_a   = g_rd_port[0].r_rdata;
    assign bus.data_b   = g_rd_port[1].r_rdata;
    assign bus.rd_valid = r_rd_valid;
    assign bus.busy     = w_busy;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised general-purpose register file for the datapath: one write port, two registered read ports, optional hardwired-zero register 0. Reset triggers a one-register-per-cycle clear sweep, so storage infers as plain RAM; a `busy` flag blocks access until the sweep finishes. Sits between the instruction decoder (addresses, `wr`/`re`) and the ALU operand inputs (`data_a`/`data_b`). Reads and writes may occur in the same cycle.

## Interface
- `DATA_W`, 8: register width in bits.
- `ADDR_W`, 3: address width; `DEPTH` = 2**`ADDR_W` registers.
- `ZERO_REG`, 1: when 1, register 0 always reads 0 and ignores writes.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `aa`  in  `ADDR_W`  read address, port A.
- `ba`  in  `ADDR_W`  read address, port B.
- `re`  in  1  read enable, both ports.
- `da`  in  `ADDR_W`  write address.
- `data_in`  in  `DATA_W`  write data.
- `wr`  in  1  write enable.
- `data_a`  out  `DATA_W`  registered read data, port A.
- `data_b`  out  `DATA_W`  registered read data, port B.
- `rd_valid`  out  1  `data_a`/`data_b` updated by a read accepted last cycle.
- `busy`  out  1  clear sweep in progress; `wr`/`re` ignored.

## Operation
- **States:** `CLEAR`, `RUN`.
- **Reset:** a cycle with `rst`=1 forces:
  - state `CLEAR`, `clr_ptr`=0;
  - `data_a`=`data_b`=0, `rd_valid`=0, `busy`=1.
  - While `rst` stays high, `clr_ptr` holds at 0.
- **`CLEAR`:** each cycle writes 0 to `mem[clr_ptr]` and increments `clr_ptr`.
  - After the cycle that writes `DEPTH-1`, go to `RUN` and clear `busy`.
  - `wr`, `re` ignored; `data_a`, `data_b` hold 0; `rd_valid`=0.
- **`RUN`, write:** `wr`=1 writes `data_in` to `mem[da]` at the clock edge.
  - Dropped when `ZERO_REG`=1 and `da`=0.
- **`RUN`, read:** `re`=1 loads `data_a` with `read(aa)` and `data_b` with `read(ba)`, and sets `rd_valid`=1.
  - `re`=0: both outputs hold and `rd_valid`=0.
  - `read(0)` returns 0 when `ZERO_REG`=1.
- **Read/write collision:** `wr` and `re` together are legal.
  - If `da` equals `aa` and/or `ba`, the result depends on `REGFILE_BYPASS_EN` (see Configuration).
  - `aa`=`ba` is legal; both ports return the same value.
- **Reset mid-operation:** `rst` has priority over everything.
  - A write in the same cycle as `rst` is lost.
  - A sweep interrupted by `rst` restarts from 0.

## Timing
- Read latency: 1 cycle, address/`re` at edge N gives data and `rd_valid` after edge N.
- Write visible to a non-bypassed read issued on the next cycle.
- `busy` is high for exactly `DEPTH` cycles after the first cycle with `rst` low; with defaults, 8 cycles.
- No combinational path from any input to any output.

## Configuration
- `REGFILE_BYPASS_EN` defined: a same-cycle write to the read address forwards `data_in` to that port, returning the new value.
  - No forwarding to register 0 when `ZERO_REG`=1.
- Not defined: the port returns the old contents (read-before-write); no forwarding mux is instantiated.

## Structure
- Shared package `regfile_pkg`:
  - state encoding `CLEAR`=1'b0, `RUN`=1'b1;
  - default `DATA_W`/`ADDR_W` constants.
- Sub-module `regfile_clear_seq`: the state register, `clr_ptr` counter and `busy`. Outputs clear-write enable, address and state.
- Top holds the storage array, write-port mux (clear vs. user), read registers and bypass.

## Test plan
- `rst` 1 cycle, then idle -> `busy`=1 for 8 cycles then 0; `re`=1 on all addresses -> all read 0.
- `rst` high 3 cycles, drop, reassert at sweep cycle 4 -> sweep restarts; `busy` spans 8 cycles after final release.
- `RUN`: write 8'hA5 to R3, next cycle `re` with `aa`=3, `ba`=3 -> `data_a`=`data_b`=8'hA5, `rd_valid`=1 one cycle later; `re`=0 -> outputs hold, `rd_valid`=0.
- `ZERO_REG`=1: write 8'hFF to R0, read `aa`=0 -> 8'h00; write to R7 unaffected.
- Collision: R2=8'h11, same cycle `wr` `da`=2 `data_in`=8'h22 with `re` `aa`=2 -> 8'h22 with `REGFILE_BYPASS_EN`, 8'h11 without. Next read -> 8'h22 in both builds.
- `wr`/`re` during `busy` -> no write lands (R5 reads 0 after sweep), `rd_valid` stays 0; repeat with `DATA_W`=16, `ADDR_W`=4 -> 16-cycle sweep.
